// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter: core (C) / debug (D) arbiter for the single-port data memory |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  // core port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // debug port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // memory side
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          owner
);

  localparam int            CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT      = CW'(STARVE_LIMIT);
  localparam logic          PORT_CORE  = 1'b0;
  localparam logic          PORT_DEBUG = 1'b1;

  logic [CW-1:0] starve_cnt;
  logic          force_d;
  logic          rd_pend;
  logic          rd_port;

  // Grants are held low during reset so the memory sees no access while rst is high.
  assign force_d = (starve_cnt == LIMIT);
  assign d_gnt   = ~rst & d_req & (~c_req | force_d);
  assign c_gnt   = ~rst & c_req & ~d_gnt;
  assign c_stall = ~rst & c_req & ~c_gnt;

  assign m_en    = c_gnt | d_gnt;
  assign m_we    = (c_gnt & c_we) | (d_gnt & d_we);
  assign m_addr  = d_gnt ? d_addr  : c_addr;
  assign m_wdata = d_gnt ? d_wdata : c_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (d_req && !d_gnt) begin
      if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + CW'(1);
    end else begin
      // Granted or withdrawn: a dropped request forfeits its credit.
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_port <= PORT_CORE;
      owner   <= PORT_CORE;
    end else begin
      rd_pend <= m_en & ~m_we;
      if (m_en) begin
        rd_port <= d_gnt ? PORT_DEBUG : PORT_CORE;
        owner   <= d_gnt ? PORT_DEBUG : PORT_CORE;
      end
    end
  end

  // Single-cycle read latency: the tag captured at grant steers the returning word.
  assign c_rvalid = rd_pend & (rd_port == PORT_CORE);
  assign d_rvalid = rd_pend & (rd_port == PORT_DEBUG);
  assign c_rdata  = c_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter: directed self-checking bench for dmem_arbiter             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          m_en, m_we, owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .owner(owner)
  );

  // Synchronous single-port memory, one-cycle read latency, preloaded on the first edge.
  logic [DW-1:0] mem [0:255];
  logic          mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 256; k++) mem[k] <= '0;
      mem[8'h10]  <= 32'hDEADBEEF;
      mem[8'h01]  <= 32'hA1A10001;
      mem[8'h02]  <= 32'hB2B20002;
      mem_loaded  <= 1'b1;
    end else if (m_en) begin
      if (m_we) mem[m_addr[7:0]] <= m_wdata;
      else      m_rdata          <= mem[m_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    // Requests during reset must not produce grants.
    c_req = 1; d_req = 1;
    @(negedge clk);
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_c_stall", c_stall, 0);
    chk("rst_rvalid", {c_rvalid, d_rvalid}, 0);
    chk("rst_owner", owner, 0);

    // Core read of 0x10
    nxt();
    rst = 0; d_req = 0; c_req = 1; c_we = 0; c_addr = 16'h0010;
    @(negedge clk);
    chk("c_rd_gnt", c_gnt, 1);
    chk("c_rd_d_gnt", d_gnt, 0);
    chk("c_rd_stall", c_stall, 0);
    chk("c_rd_m_en", m_en, 1);
    chk("c_rd_m_we", m_we, 0);
    chk("c_rd_m_addr", m_addr, 16'h0010);
    nxt();
    c_req = 0;
    @(negedge clk);
    chk("c_rd_rvalid", c_rvalid, 1);
    chk("c_rd_rdata", c_rdata, 32'hDEADBEEF);
    chk("c_rd_d_rvalid", d_rvalid, 0);
    chk("c_rd_d_rdata", d_rdata, 0);
    chk("c_rd_owner", owner, 0);

    // Continuous contention: C,C,C,C,D repeating
    nxt();
    c_req = 1; c_addr = 16'h0000; d_req = 1; d_we = 0; d_addr = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("starve_c_gnt", c_gnt, (i % 5) != 4);
      chk("starve_d_gnt", d_gnt, (i % 5) == 4);
      chk("starve_c_stall", c_stall, (i % 5) == 4);
      chk("starve_cnt", dut.starve_cnt, i % 5);
      if (i == 5) chk("starve_d_rvalid", {c_rvalid, d_rvalid}, 2'b01);
      nxt();
    end
    c_req = 0; d_req = 0;
    @(negedge clk);
    chk("starve_cnt_after_d", dut.starve_cnt, 0);
    chk("starve_d_rvalid2", d_rvalid, 1);

    // Debug-only write then read-back
    nxt();
    d_req = 1; d_we = 1; d_addr = 16'h0003; d_wdata = 32'h000055AA;
    @(negedge clk);
    chk("d_wr_gnt", d_gnt, 1);
    chk("d_wr_c_gnt", c_gnt, 0);
    chk("d_wr_m_we", m_we, 1);
    chk("d_wr_m_addr", m_addr, 16'h0003);
    chk("d_wr_m_wdata", m_wdata, 32'h000055AA);
    nxt();
    d_we = 0;
    @(negedge clk);
    chk("d_rd_gnt", d_gnt, 1);
    chk("d_rd_m_we", m_we, 0);
    chk("d_wr_no_rvalid", d_rvalid, 0);
    nxt();
    d_req = 0;
    @(negedge clk);
    chk("d_rd_rvalid", d_rvalid, 1);
    chk("d_rd_rdata", d_rdata, 32'h000055AA);
    chk("d_rd_core_idle", {c_gnt, c_stall, c_rvalid}, 0);
    chk("d_rd_c_rdata", c_rdata, 0);
    chk("d_rd_owner", owner, 1);

    // C-read addr1 then forced D-read addr2
    nxt();
    c_req = 1; c_addr = 16'h0001; d_req = 1; d_addr = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_c_gnt", c_gnt, 1);
      nxt();
    end
    @(negedge clk);
    chk("alt_d_gnt", d_gnt, 1);
    chk("alt_c_rvalid", {c_rvalid, d_rvalid}, 2'b10);
    chk("alt_c_rdata", c_rdata, 32'hA1A10001);
    chk("alt_d_rdata0", d_rdata, 0);
    nxt();
    c_req = 0; d_req = 0;
    @(negedge clk);
    chk("alt_d_rvalid", {c_rvalid, d_rvalid}, 2'b01);
    chk("alt_d_rdata", d_rdata, 32'hB2B20002);
    chk("alt_c_rdata0", c_rdata, 0);
    chk("alt_owner", owner, 1);

    // Reset one cycle after a granted read
    nxt();
    c_req = 1; c_addr = 16'h0001; d_req = 1; d_addr = 16'h0002;
    nxt();
    nxt();
    rst = 1;
    #1;
    chk("mid_rst_rvalid", {c_rvalid, d_rvalid}, 0);
    chk("mid_rst_c_rdata", c_rdata, 0);
    chk("mid_rst_cnt", dut.starve_cnt, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_gnt", {c_gnt, d_gnt, c_stall}, 0);
    chk("mid_rst_m", {m_en, m_we}, 0);
    nxt();
    rst = 0; c_req = 0; d_req = 0;
    @(negedge clk);
    chk("post_rst_rvalid", {c_rvalid, d_rvalid}, 0);

    // Dropped debug request loses its starvation credit
    nxt();
    c_req = 1; c_addr = 16'h0000; d_req = 1; d_addr = 16'h0000;
    repeat (3) nxt();
    d_req = 0;
    @(negedge clk);
    chk("drop_cnt3", dut.starve_cnt, 3);
    nxt();
    d_req = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drop_d_gnt", d_gnt, i == 4);
      chk("drop_cnt", dut.starve_cnt, i);
      nxt();
    end
    c_req = 0; d_req = 0;
    repeat (2) nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
